adder_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit adder datapath between two requesters (ports 0/1) on the tt_um_adder tile.

---
 rtl/adder_share_arbiter_pkg.sv | 17 +
 rtl/adder_share_arbiter_if.sv | 36 +++
 rtl/adder_share_arbiter_core.sv | 20 ++
 rtl/adder_share_arbiter.sv | 126 ++++++++++++
 tb/tb_adder_share_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants and types for the two-port shared-adder arbiter.
//   state_e    : arbiter state (ST_IDLE / ST_LOCKED)
//   DEF_WIDTH  : default operand/sum width per beat
//   PORT0/1    : requester index constants
package adder_share_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between the two requesters and the shared adder.
//   req_valid/req_ready  : per-requester handshake (2 bits each)
//   req_a/req_b          : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin/req_last     : per-requester carry-in (first beat) and end-of-burst
//   rsp_*                : one-entry response with valid/ready handshake
// slave modport is the arbiter side, master modport the requester/consumer side.
interface adder_share_arbiter_if
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         req_cin;
  logic [1:0]         req_last;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_sum;
  logic               rsp_cout;
  logic               rsp_id;
  logic               rsp_last;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
  );

endinterface

// File: rtl/adder_share_arbiter_core.sv
// Combinational WIDTH-bit adder: {cout_o, sum_o} = a_i + b_i + cin_i.
//   a_i, b_i : operands
//   cin_i    : carry-in
//   sum_o    : WIDTH-bit wrapped sum
//   cout_o   : carry-out
module adder_share_arbiter_core
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i) + (WIDTH+1)'(cin_i);

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder between two requesters, with burst
// locking, carry chaining between beats and a one-entry response register.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of adder_share_arbiter_if (request + response)
// LOCK_EN=1 holds the grant from the first beat to the req_last beat;
// LOCK_EN=0 re-arbitrates every beat.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter bit          LOCK_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  adder_share_arbiter_if.slave  bus
);

  state_e           state_q;
  logic             owner_q;
  logic             prio_q;
  logic             carry_q;
  logic             chain_vld_q;
  logic             chain_id_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic             rsp_id_q;
  logic             rsp_last_q;

  logic             out_free_c;
  logic             gnt_vld_c;
  logic             gnt_id_c;
  logic             xfer_c;
  logic [1:0]       req_ready_c;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic             cin_c;
  logic             last_c;
  logic [WIDTH-1:0] rsp_sum_d;
  logic             rsp_cout_d;

  // Response slot can take a new beat when empty or being drained this cycle.
  assign out_free_c = !rsp_valid_q || bus.rsp_ready;

  // Grant selection: owner only while locked, otherwise prio first.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_id_c  = PORT0;
    if (state_q == ST_LOCKED) begin
      gnt_vld_c = bus.req_valid[owner_q];
      gnt_id_c  = owner_q;
    end else if (bus.req_valid[prio_q]) begin
      gnt_vld_c = 1'b1;
      gnt_id_c  = prio_q;
    end else if (bus.req_valid[~prio_q]) begin
      gnt_vld_c = 1'b1;
      gnt_id_c  = ~prio_q;
    end
  end

  assign xfer_c      = gnt_vld_c && out_free_c;
  assign req_ready_c = xfer_c ? 2'(2'b01 << gnt_id_c) : 2'b00;

  // Operand mux for the granted requester.
  always_comb begin
    a_c    = (gnt_id_c == PORT1) ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
    b_c    = (gnt_id_c == PORT1) ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
    last_c = bus.req_last[gnt_id_c];
    // Chain the stored carry only when the immediately preceding transfer was
    // a non-final beat from this same requester.
    cin_c  = (chain_vld_q && (chain_id_q == gnt_id_c)) ? carry_q : bus.req_cin[gnt_id_c];
  end

  adder_share_arbiter_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (a_c),
    .b_i    (b_c),
    .cin_i  (cin_c),
    .sum_o  (rsp_sum_d),
    .cout_o (rsp_cout_d)
  );

  // Arbiter FSM, round-robin priority, carry chain and response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT0;
      prio_q      <= PORT0;
      carry_q     <= 1'b0;
      chain_vld_q <= 1'b0;
      chain_id_q  <= PORT0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= PORT0;
      rsp_last_q  <= 1'b0;
    end else if (xfer_c) begin
      rsp_valid_q <= 1'b1;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= gnt_id_c;
      rsp_last_q  <= last_c;
      carry_q     <= last_c ? 1'b0 : rsp_cout_d;
      chain_vld_q <= !last_c;
      chain_id_q  <= gnt_id_c;
      if (last_c) begin
        state_q <= ST_IDLE;
        prio_q  <= ~gnt_id_c;
      end else if (LOCK_EN) begin
        state_q <= ST_LOCKED;
        owner_q <= gnt_id_c;
      end else begin
        prio_q  <= ~gnt_id_c;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter (WIDTH=4, LOCK_EN=1): directed
// scenarios plus a randomized run against a behavioural reference model.
module tb_adder_share_arbiter;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.WIDTH(W)) bus ();

  adder_share_arbiter #(.WIDTH(W), .LOCK_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // {rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last}
  logic [7:0] rsp_obs;
  assign rsp_obs = {bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, bus.rsp_last};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 2'b00;
    bus.req_last  = 2'b00;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic drive(input int p, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic last);
    bus.req_a[p*W +: W] = a;
    bus.req_b[p*W +: W] = b;
    bus.req_cin[p]      = cin;
    bus.req_last[p]     = last;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (rsp_obs !== 8'b0) begin
      n_fail++; $display("FAIL reset_rsp: got %b want %b", rsp_obs, 8'b0);
    end
    n_tests++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready_idle: got %b want 00", bus.req_ready);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    drive(0, 4'h3, 4'h4, 1'b1, 1'b1);
    bus.req_valid = 2'b01;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_ready: got %b want 01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h8, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL single_rsp: got %b want %b", rsp_obs, {1'b1, 4'h8, 1'b0, 1'b0, 1'b1});
    end
    tick();
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_collision();
    do_reset();
    drive(0, 4'h1, 4'h1, 1'b0, 1'b1);
    drive(1, 4'h2, 4'h2, 1'b0, 1'b1);
    bus.req_valid = 2'b11;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL coll_ready0: got %b want 01", bus.req_ready);
    end
    tick();
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h2, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL coll_rsp0: got %b want %b", rsp_obs, {1'b1, 4'h2, 1'b0, 1'b0, 1'b1});
    end
    n_tests++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL coll_ready1: got %b want 10", bus.req_ready);
    end
    tick();
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h4, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL coll_rsp1: got %b want %b", rsp_obs, {1'b1, 4'h4, 1'b0, 1'b1, 1'b1});
    end
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL coll_ready2: got %b want 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_burst_chain();
    do_reset();
    drive(1, 4'hF, 4'h1, 1'b0, 1'b0);
    bus.req_valid = 2'b10;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL burst_ready_first: got %b want 10", bus.req_ready);
    end
    tick();
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL burst_rsp_first: got %b want %b", rsp_obs, {1'b1, 4'h0, 1'b1, 1'b1, 1'b0});
    end
    // Owner idles for a cycle; the other port must still be blocked.
    drive(0, 4'h7, 4'h0, 1'b0, 1'b1);
    bus.req_valid = 2'b01;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL burst_lock_block: got %b want 00", bus.req_ready);
    end
    tick();
    // Last beat with req_cin=1 which must be ignored in favour of the chained carry.
    drive(1, 4'h0, 4'h0, 1'b1, 1'b1);
    bus.req_valid = 2'b11;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL burst_ready_last: got %b want 10", bus.req_ready);
    end
    tick();
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h1, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL burst_rsp_last: got %b want %b", rsp_obs, {1'b1, 4'h1, 1'b0, 1'b1, 1'b1});
    end
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL burst_release: got %b want 01", bus.req_ready);
    end
    tick();
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h7, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL burst_rsp_p0: got %b want %b", rsp_obs, {1'b1, 4'h7, 1'b0, 1'b0, 1'b1});
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, 4'h5, 4'h6, 1'b0, 1'b1);
    bus.req_valid = 2'b01;
    tick();
    bus.rsp_ready = 1'b0;
    drive(1, 4'h2, 4'h3, 1'b0, 1'b1);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (bus.req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b want 00", i, bus.req_ready);
      end
      n_tests++;
      if (rsp_obs !== {1'b1, 4'hB, 1'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b want %b", i, rsp_obs, {1'b1, 4'hB, 1'b0, 1'b0, 1'b1});
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_b2b_ready: got %b want 10", bus.req_ready);
    end
    tick();
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h5, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL bp_b2b_rsp: got %b want %b", rsp_obs, {1'b1, 4'h5, 1'b0, 1'b1, 1'b1});
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    drive(0, 4'hF, 4'hF, 1'b1, 1'b1);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    n_tests++;
    if (rsp_obs !== {1'b1, 4'hF, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL overflow: got %b want %b", rsp_obs, {1'b1, 4'hF, 1'b1, 1'b0, 1'b1});
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(0, 4'hF, 4'h1, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    tick();
    // Reset while p0 holds the lock with carry=1 and a response pending.
    reset = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    reset = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    drive(0, 4'h1, 4'h1, 1'b0, 1'b1);
    drive(1, 4'h2, 4'h2, 1'b0, 1'b1);
    bus.req_valid = 2'b11;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b want 01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    n_tests++;
    if (rsp_obs !== {1'b1, 4'h2, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rst_mid_cin: got %b want %b", rsp_obs, {1'b1, 4'h2, 1'b0, 1'b0, 1'b1});
    end
    tick();
  endtask

  // Random traffic checked against a behavioural model: owner = -1 when no
  // burst is open, chain = requester whose previous beat left a carry open.
  task automatic test_random();
    int owner, prio, chain, carry, gnt, total;
    bit m_rv;
    logic [7:0] m_rsp;
    logic [1:0] exp_ready;
    logic [3:0] a, b;
    logic       rsp_rdy;
    do_reset();
    owner = -1; prio = 0; chain = -1; carry = 0; m_rv = 0; m_rsp = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++)
        drive(p, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      rsp_rdy = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = rsp_rdy;
      #1;
      gnt = -1;
      if (!m_rv || rsp_rdy) begin
        if (owner >= 0) begin
          if (bus.req_valid[owner]) gnt = owner;
        end else if (bus.req_valid[prio]) gnt = prio;
        else if (bus.req_valid[1-prio]) gnt = 1 - prio;
      end
      exp_ready = (gnt < 0) ? 2'b00 : ((gnt == 0) ? 2'b01 : 2'b10);
      n_tests++;
      if (bus.req_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus.req_ready, exp_ready);
      end
      n_tests++;
      if (bus.rsp_valid !== m_rv || (m_rv && rsp_obs !== m_rsp)) begin
        n_fail++; $display("FAIL rand_rsp@%0d: got %b want %b", cyc, rsp_obs, m_rsp);
      end
      if (gnt >= 0) begin
        a = bus.req_a[gnt*W +: W];
        b = bus.req_b[gnt*W +: W];
        total = int'(a) + int'(b) + ((chain == gnt) ? carry : int'(bus.req_cin[gnt]));
        m_rv  = 1;
        m_rsp = {1'b1, 4'(total % 16), 1'(total / 16), 1'(gnt), bus.req_last[gnt]};
        if (bus.req_last[gnt]) begin
          owner = -1; chain = -1; carry = 0; prio = 1 - gnt;
        end else begin
          owner = gnt; chain = gnt; carry = total / 16;
        end
      end else if (rsp_rdy) begin
        m_rv = 0;
        m_rsp = '0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_beat();
    test_collision();
    test_burst_chain();
    test_backpressure();
    test_overflow();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
